// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - write-back trace capture FIFO with sequence tags and drop accounting
// Head outputs come straight from the storage registers, so nothing combinational reaches them from inputs.
module wb_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int SEQ_W     = 8,
  parameter int CNT_W     = 16,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = SEQ_W + 5 + 32;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [SEQ_W-1:0] seq;
  logic [EW-1:0]    head;
  logic             evt;
  logic             push;
  logic             pop;
  logic             drop;

  // Filtered x0 writes never consume a sequence number.
  assign evt  = capture_en && wb_valid && !(FILTER_X0 && (wb_rd == 5'd0));
  assign pop  = out_valid && out_ready;
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  assign out_valid = (cnt != '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  assign head      = mem[rd_ptr];
  assign {out_seq, out_rd, out_data} = out_valid ? head : '0;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      // Dropped events still burn a tag so consumers see the gap.
      if (evt) seq <= seq + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  // When full with a concurrent pop, wr_ptr equals rd_ptr: the head is read this cycle and replaced at the edge.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push) mem[wr_ptr] <= {seq, wb_rd, wb_data};
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - self-checking bench for wb_trace_buffer against a queue model
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [7:0]  seq;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic        clear = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_seq;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic [15:0] drop_count;

  ent_t q[$];
  int   m_seq = 0;
  int   m_drops = 0;
  bit   m_ovf = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   saw_wrap = 1'b0;
  logic [7:0] prev_seq = '0;
  bit   prev_vld = 1'b0;

  wb_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(8), .CNT_W(16), .FILTER_X0(1'b1)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .clear(clear),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_rd(out_rd), .out_data(out_data), .count(count), .full(full),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a plain queue of entries with the capture rules applied directly.
  task automatic model_edge();
    bit evt, was_full, popped;
    if (reset || clear) begin
      q.delete();
      m_seq = 0;
      m_drops = 0;
      m_ovf = 1'b0;
      return;
    end
    evt      = capture_en && wb_valid && (wb_rd != 5'd0);
    was_full = (q.size() == DEPTH);
    popped   = (q.size() != 0) && out_ready;
    if (popped) void'(q.pop_front());
    if (evt) begin
      if (!was_full || popped) q.push_back('{seq: 8'(m_seq), rd: wb_rd, data: wb_data});
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      m_seq = (m_seq + 1) % 256;
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(out_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
    if (q.size() != 0) begin
      chk("head", 64'({out_seq, out_rd, out_data}), 64'(q[0]));
    end else begin
      chk("head_zero", 64'({out_seq, out_rd, out_data}), 64'(0));
    end
    if (prev_vld && out_valid && prev_seq == 8'd255 && out_seq == 8'd0) saw_wrap = 1'b1;
    prev_vld = out_valid;
    prev_seq = out_seq;
  endtask

  task automatic step(input bit cap, input bit clr, input bit rst, input bit v,
                      input logic [4:0] rd, input logic [31:0] data, input bit rdy);
    capture_en = cap; clear = clr; reset = rst; wb_valid = v;
    wb_rd = rd; wb_data = data; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ev(input logic [4:0] rd, input logic [31:0] data, input bit rdy);
    step(1'b1, 1'b0, 1'b0, 1'b1, rd, data, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #1;
    do_reset();
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));

    // Three events with a ready consumer
    ev(5'd1, 32'hA, 1'b1);
    chk("t1_latency", 64'(out_valid), 64'(1));
    chk("t1_first", 64'({out_seq, out_rd, out_data}), 64'({8'd0, 5'd1, 32'hA}));
    ev(5'd2, 32'hB, 1'b1);
    ev(5'd3, 32'hC, 1'b1);
    idle(1'b1);
    chk("t1_empty", 64'(count), 64'(0));

    // Overfill with consumer stalled
    do_reset();
    for (int i = 0; i < 18; i++) begin
      ev(5'(1 + (i % 31)), 32'(i * 7), 1'b0);
      if (i == 15) chk("t2_full", 64'(full), 64'(1));
    end
    chk("t2_drops", 64'(drop_count), 64'(2));
    chk("t2_ovf", 64'(overflow), 64'(1));
    for (int i = 0; i < 16; i++) begin
      chk("t2_seq", 64'(out_seq), 64'(i));
      idle(1'b1);
    end

    // Full FIFO with simultaneous event and pop
    do_reset();
    for (int i = 0; i < 16; i++) ev(5'd4, 32'(i), 1'b0);
    ev(5'd6, 32'hBEEF, 1'b1);
    chk("t3_count", 64'(count), 64'(16));
    chk("t3_drops", 64'(drop_count), 64'(0));
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("t3_last", 64'({out_seq, out_rd, out_data}), 64'({8'd16, 5'd6, 32'hBEEF}));
    idle(1'b1);

    // x0 filter and capture disable
    do_reset();
    ev(5'd0, 32'h11, 1'b0);
    ev(5'd5, 32'h55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0);
    chk("t4_count", 64'(count), 64'(1));
    chk("t4_head", 64'({out_seq, out_rd}), 64'({8'd0, 5'd5}));
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t4_drained", 64'(count), 64'(0));

    // Sequence wrap under continuous drain
    do_reset();
    saw_wrap = 1'b0;
    for (int i = 0; i < 300; i++) ev(5'($urandom_range(1, 31)), $urandom, 1'b1);
    idle(1'b1);
    chk("t5_wrap", 64'(saw_wrap), 64'(1));
    chk("t5_drops", 64'(drop_count), 64'(0));

    // Reset, then clear, each with 5 entries held and a concurrent event
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 18; i++) ev(5'd8, 32'(i), 1'b0);
      for (int i = 0; i < 11; i++) idle(1'b1);
      chk("t6_held", 64'(count), 64'(5));
      step(1'b1, k == 1, k == 0, 1'b1, 5'd9, 32'h99, 1'b0);
      chk("t6_valid", 64'(out_valid), 64'(0));
      chk("t6_count", 64'(count), 64'(0));
      chk("t6_drops", 64'(drop_count), 64'(0));
      ev(5'd10, 32'hAA, 1'b0);
      chk("t6_seq", 64'(out_seq), 64'(0));
    end

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
